key_scan: RTL and testbench
===========================

KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000, is the system clocks per debounce tick (1 kHz at 50 MHz).
REQ-002 Parameter DEBOUNCE_MS, default 20, is the consecutive ticks a raw level must hold before acceptance; legal range 2..31.
REQ-003 clk  input  1  is the single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  is the asynchronous, active-high reset.
REQ-005 key_in  input  6  carries raw, asynchronous, active-low push-buttons; bit i is key i.
REQ-006 key_vaild  output  1  is high while a debounced key is held and latched.
REQ-007 key_code  output  4  is the index (0..5) of the latched key; valid only while key_vaild=1.
REQ-008 key_press  output  1  is a one-clk pulse on the cycle key_vaild rises.
REQ-009 key_release  output  1  is a one-clk pulse on the cycle key_vaild falls.

Function
REQ-010 Each key_in bit SHALL pass a 2-flop synchronizer, then be inverted so that a pressed key reads as 1.
REQ-011 Tick counter SHALL count 0..CLK_DIV-1 and wrap; tick=1 for exactly one clk when count==CLK_DIV-1.
REQ-012 Per-key debounce: if sync==stable, the key counter SHALL clear on any cycle; otherwise the counter SHALL increment on tick.
REQ-013 When a differing key's counter equals DEBOUNCE_MS-1 on a tick, stable SHALL take the sync value and the counter SHALL clear in the same cycle.
REQ-014 A glitch shorter than DEBOUNCE_MS ticks SHALL NOT change stable.
REQ-015 Accept latency SHALL be 2 sync clks plus DEBOUNCE_MS ticks, with first-tick phase uncertainty of at most CLK_DIV clks.
REQ-016 FSM states are IDLE, HOLD and WAIT_UP.
REQ-017 IDLE, with any stable bit set: go to HOLD, latch key_code = lowest set index, assert key_vaild and pulse key_press, all registered on the same edge.
REQ-018 HOLD: key_code SHALL NOT change when other keys press or release.
REQ-019 HOLD, latched key's stable bit clears, no other stable bit set: go to IDLE, deassert key_vaild, pulse key_release.
REQ-020 HOLD, latched key's stable bit clears, other stable bits still set: go to WAIT_UP, deassert key_vaild, pulse key_release.
REQ-021 WAIT_UP SHALL return to IDLE only when all stable bits are 0, and SHALL NOT start a new press meanwhile (no phantom press).
REQ-022 Simultaneous debounced presses accepted on the same tick: the lowest index wins.
REQ-023 key_press and key_release SHALL never be high in the same cycle.
REQ-024 key_vaild SHALL never be high outside HOLD.

Reset
REQ-025 Asserting reset SHALL asynchronously clear the synchronizers, stable bits, debounce counters, tick counter, FSM (to IDLE) and all outputs: key_vaild=0, key_code=0, key_press=0, key_release=0.
REQ-026 Synchronizers reset to released (raw 1, pressed 0).
REQ-027 Reset mid-HOLD SHALL produce no key_release pulse.
REQ-028 After deassertion, a key already held SHALL be reported only after a full debounce interval.

Structure
REQ-029 Package key_pkg SHALL hold KEY_NUM=6, KEY_CODE_W=4 and the FSM state encoding.
REQ-030 Sub-module key_debounce (one channel: synchronizer, counter, stable bit, tick input) SHALL be instantiated KEY_NUM times.
REQ-031 The tick generator, encoder and FSM SHALL reside in key_scan.

Verification (CLK_DIV=4, DEBOUNCE_MS=3)
REQ-032 Hold key_in=6'b111011 for 40 clks -> key_press pulse and key_vaild=1, key_code=2 within 2+3*4+4 clks; release -> key_release pulse, key_vaild=0.
REQ-033 Low pulse on key 0 lasting 8 clks (<3 ticks) -> key_vaild stays 0, no pulses.
REQ-034 Keys 1 and 4 pressed on the same clk -> key_code=1; then release key 1 with key 4 held -> key_release, state WAIT_UP, no new key_press until all keys are released.
REQ-035 Key 3 held, then key 0 pressed -> key_code remains 3.
REQ-036 Assert reset while key 5 is latched -> all outputs 0 immediately and no key_release; deassert with key 5 held -> key_press again after the full debounce interval.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants, FSM encoding and the priority helper for the key scanner.
package key_pkg;

  localparam int KEY_NUM    = 6;
  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    WAIT_UP = 2'd2
  } state_e;

  function automatic logic [KEY_CODE_W-1:0] lowest_idx(
    input logic [KEY_NUM-1:0] v
  );
    lowest_idx = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = KEY_CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchronizer, tick-driven
// debounce counter and the accepted (stable) pressed level.
module key_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic key_n,
  output logic stable
);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic [4:0] cnt_q, cnt_d;
  logic       stable_q, stable_d;
  logic       pressed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign pressed = ~sync_q;

  always_comb begin
    meta_d   = key_n;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (pressed == stable_q) begin
      cnt_d = '0;
    end else if (tick) begin
      // Accept on the DEBOUNCE_MS-th consecutive tick of the new level.
      if (cnt_q == 5'(DEBOUNCE_MS - 1)) begin
        stable_d = pressed;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/key_scan.sv
// Six-key scanner: per-key debounce, shared tick, lowest-index
// priority and a press/hold/wait-for-release FSM.
module key_scan
  import key_pkg::*;
#(
  parameter int CLK_DIV     = 50000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [KEY_NUM-1:0]    key_in,
  output logic                  key_vaild,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_press,
  output logic                  key_release
);

  localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [KEY_NUM-1:0] stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  assign tick = (tick_cnt_q == TICK_W'(CLK_DIV - 1));

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .key_n (key_in[i]),
      .stable(stable[i])
    );
  end

  state_e                state_q, state_d;
  logic                  vaild_q, vaild_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;
  logic                  press_q, press_d;
  logic                  rel_q, rel_d;
  logic                  held;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vaild_q <= 1'b0;
      code_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vaild_q <= vaild_d;
      code_q  <= code_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    held = 1'b0;
    for (int i = 0; i < KEY_NUM; i++) begin
      if (code_q == KEY_CODE_W'(i)) held = stable[i];
    end
  end

  always_comb begin
    state_d = state_q;
    vaild_d = vaild_q;
    code_d  = code_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|stable) begin
          state_d = HOLD;
          code_d  = lowest_idx(stable);
          vaild_d = 1'b1;
          press_d = 1'b1;
        end
      end
      HOLD: begin
        if (!held) begin
          // Others still down: block re-press until all are up.
          state_d = (|stable) ? WAIT_UP : IDLE;
          vaild_d = 1'b0;
          rel_d   = 1'b1;
        end
      end
      WAIT_UP: begin
        if (stable == '0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        vaild_d = 1'b0;
      end
    endcase
  end

  assign key_vaild   = vaild_q;
  assign key_code    = code_q;
  assign key_press   = press_q;
  assign key_release = rel_q;

endmodule

// File: tb/tb_key_scan.sv
// Directed vector table plus reset and glitch sequences
// for key_scan with CLK_DIV=4, DEBOUNCE_MS=3.
module tb_key_scan;
  import key_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] key_in;
  logic       key_vaild;
  logic [3:0] key_code;
  logic       key_press;
  logic       key_release;

  int checks = 0;
  int errors = 0;
  int press_n = 0;
  int rel_n = 0;
  int overlap_n = 0;
  int vbad_n = 0;

  key_scan #(
    .CLK_DIV    (4),
    .DEBOUNCE_MS(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_vaild  (key_vaild),
    .key_code   (key_code),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_press) press_n++;
    if (key_release) rel_n++;
    if (key_press && key_release) overlap_n++;
    if (key_vaild && dut.state_q != HOLD) vbad_n++;
  end

  typedef struct {
    logic [5:0] key;
    int         clks;
    logic       vaild;
    logic [3:0] code;
    int         press;
    int         rel;
    state_e     st;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int p0, r0, waited;

  initial begin
    vecs[0]  = '{6'b111111, 40, 1'b0, 4'd0, 0, 0, IDLE};
    vecs[1]  = '{6'b111011, 40, 1'b1, 4'd2, 1, 0, HOLD};
    vecs[2]  = '{6'b111111, 40, 1'b0, 4'd0, 0, 1, IDLE};
    vecs[3]  = '{6'b101101, 40, 1'b1, 4'd1, 1, 0, HOLD};
    vecs[4]  = '{6'b101111, 40, 1'b0, 4'd0, 0, 1, WAIT_UP};
    vecs[5]  = '{6'b101111, 40, 1'b0, 4'd0, 0, 0, WAIT_UP};
    vecs[6]  = '{6'b111111, 40, 1'b0, 4'd0, 0, 0, IDLE};
    vecs[7]  = '{6'b110111, 40, 1'b1, 4'd3, 1, 0, HOLD};
    vecs[8]  = '{6'b110110, 40, 1'b1, 4'd3, 0, 0, HOLD};
    vecs[9]  = '{6'b110111, 40, 1'b1, 4'd3, 0, 0, HOLD};
    vecs[10] = '{6'b111111, 40, 1'b0, 4'd0, 0, 1, IDLE};
    vecs[11] = '{6'b011111, 40, 1'b1, 4'd5, 1, 0, HOLD};

    reset  = 1'b1;
    key_in = 6'b111111;
    step(3);
    chk("rst vaild", int'(key_vaild), 0);
    chk("rst code", int'(key_code), 0);
    chk("rst press", int'(key_press), 0);
    chk("rst release", int'(key_release), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      p0 = press_n;
      r0 = rel_n;
      key_in = vecs[i].key;
      step(vecs[i].clks);
      chk($sformatf("v%0d vaild", i), int'(key_vaild), int'(vecs[i].vaild));
      if (vecs[i].vaild)
        chk($sformatf("v%0d code", i), int'(key_code), int'(vecs[i].code));
      chk($sformatf("v%0d press", i), press_n - p0, vecs[i].press);
      chk($sformatf("v%0d release", i), rel_n - r0, vecs[i].rel);
      chk($sformatf("v%0d state", i), int'(dut.state_q), int'(vecs[i].st));
    end

    // Reset while key 5 is latched, then re-debounce on release of reset.
    r0 = rel_n;
    reset = 1'b1;
    #1;
    chk("mid rst vaild", int'(key_vaild), 0);
    chk("mid rst code", int'(key_code), 0);
    chk("mid rst press", int'(key_press), 0);
    chk("mid rst release", int'(key_release), 0);
    step(3);
    reset = 1'b0;
    p0 = press_n;
    step(10);
    chk("early press", press_n - p0, 0);
    waited = 0;
    while (press_n == p0 && waited < 20) begin
      step(1);
      waited++;
    end
    if (press_n == p0) begin
      errors++;
      $display("FAIL repress timeout: got 0 presses required 1");
    end
    step(1);
    chk("repress vaild", int'(key_vaild), 1);
    chk("repress code", int'(key_code), 5);
    chk("rst no release", rel_n - r0, 0);

    key_in = 6'b111111;
    step(40);
    chk("rel5 vaild", int'(key_vaild), 0);
    chk("rel5 release", rel_n - r0, 1);

    // 8-clk glitch on key 0 is shorter than three ticks.
    p0 = press_n;
    key_in = 6'b111110;
    step(8);
    key_in = 6'b111111;
    step(30);
    chk("glitch press", press_n - p0, 0);
    chk("glitch vaild", int'(key_vaild), 0);

    chk("press+release overlap", overlap_n, 0);
    chk("vaild outside HOLD", vbad_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
